// File: rtl/mem_access_unit.sv
// Load/store sequencer between the execute stage and the word-banked data memory.
// Define MEM_ACCESS_BOUNDS_CHECK_EN to fault on addresses at or beyond MEM_BYTES.
module mem_access_unit #(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_signed,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_resp_valid,
  input  logic        i_resp_ready,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_fault,
  output logic [31:0] o_mem_address,
  output logic [31:0] o_mem_wr_data,
  output logic [1:0]  o_mem_wr_mask,
  output logic [2:0]  o_mem_rd_mask,
  input  logic [31:0] i_mem_rd_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

  localparam logic [2:0] RD_W    = 3'd0;
  localparam logic [2:0] RD_HZ   = 3'd1;
  localparam logic [2:0] RD_BZ   = 3'd2;
  localparam logic [2:0] RD_HE   = 3'd3;
  localparam logic [2:0] RD_BE   = 3'd4;
  localparam logic [2:0] RD_NONE = 3'd5;

  if ((MEM_BYTES & (MEM_BYTES - 1)) != 0) begin : g_bad_mem_bytes
    $error("MEM_BYTES must be a power of two");
  end

  state_t      state;
  logic        req_we;
  logic        req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_fault;

  // NOTE: every variable written in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    req_fault = 1'b0;
    case (i_req_size)
      2'd1:    req_fault = i_req_addr[0];
      2'd2:    req_fault = |i_req_addr[1:0];
      2'd3:    req_fault = 1'b1;
      default: req_fault = 1'b0;
    endcase
`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
    if (i_req_addr >= MEM_BYTES) req_fault = 1'b1;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state        <= IDLE;
      req_we       <= 1'b0;
      req_signed   <= 1'b0;
      req_size     <= 2'd0;
      req_addr     <= 32'd0;
      req_wdata    <= 32'd0;
      o_resp_rdata <= 32'd0;
      o_resp_fault <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_req_valid) begin
            req_we     <= i_req_we;
            req_signed <= i_req_signed;
            req_size   <= i_req_size;
            req_addr   <= i_req_addr;
            req_wdata  <= i_req_wdata;
            if (req_fault) begin
              o_resp_fault <= 1'b1;
              o_resp_rdata <= 32'd0;
              state        <= RESP;
            end else begin
              state <= ACCESS;
            end
          end
        end
        ACCESS: state <= CAPTURE;
        CAPTURE: begin
          o_resp_rdata <= req_we ? 32'd0 : i_mem_rd_data;
          state        <= RESP;
        end
        RESP: begin
          if (i_resp_ready) begin
            o_resp_rdata <= 32'd0;
            o_resp_fault <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_req_ready   = (state == IDLE);
  assign o_resp_valid  = (state == RESP);
  assign o_mem_address = req_addr;
  assign o_mem_wr_data = req_wdata;

  // Masks decode straight from the state register so an async reset in ACCESS kills the write.
  always_comb begin
    o_mem_wr_mask = 2'd0;
    o_mem_rd_mask = RD_NONE;
    if (state == ACCESS) begin
      if (req_we) begin
        o_mem_wr_mask = req_size + 2'd1;
      end else begin
        case (req_size)
          2'd0:    o_mem_rd_mask = req_signed ? RD_BE : RD_BZ;
          2'd1:    o_mem_rd_mask = req_signed ? RD_HE : RD_HZ;
          default: o_mem_rd_mask = RD_W;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a behavioural word-banked memory.
// Honours MEM_ACCESS_BOUNDS_CHECK_EN for the out-of-range store case.
module tb_mem_access_unit;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          lat;
    int          acc;
  } exp_t;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic        i_req_we = 1'b0;
  logic [1:0]  i_req_size = 2'd0;
  logic        i_req_signed = 1'b0;
  logic [31:0] i_req_addr = 32'd0;
  logic [31:0] i_req_wdata = 32'd0;
  logic        o_resp_valid;
  logic        i_resp_ready = 1'b1;
  logic [31:0] o_resp_rdata;
  logic        o_resp_fault;
  logic [31:0] o_mem_address;
  logic [31:0] o_mem_wr_data;
  logic [1:0]  o_mem_wr_mask;
  logic [2:0]  o_mem_rd_mask;
  logic [31:0] i_mem_rd_data = 32'd0;

  mem_access_unit #(.MEM_BYTES(4096)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_we(i_req_we), .i_req_size(i_req_size), .i_req_signed(i_req_signed),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
    .o_resp_rdata(o_resp_rdata), .o_resp_fault(o_resp_fault),
    .o_mem_address(o_mem_address), .o_mem_wr_data(o_mem_wr_data),
    .o_mem_wr_mask(o_mem_wr_mask), .o_mem_rd_mask(o_mem_rd_mask),
    .i_mem_rd_data(i_mem_rd_data)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  exp_t q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Little-endian memory, 4 KiB, upper address bits alias.
  logic [31:0] mem [0:1023];
  initial for (int i = 0; i < 1024; i++) mem[i] = 32'd0;

  always @(posedge i_clk) begin : mem_model
    logic [9:0]  idx;
    logic [1:0]  lane;
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    idx  = o_mem_address[11:2];
    lane = o_mem_address[1:0];
    w    = mem[idx];
    b    = w[8*lane +: 8];
    h    = w[16*lane[1] +: 16];
    case (o_mem_wr_mask)
      2'd1: mem[idx][8*lane +: 8] <= o_mem_wr_data[7:0];
      2'd2: mem[idx][16*lane[1] +: 16] <= o_mem_wr_data[15:0];
      2'd3: mem[idx] <= o_mem_wr_data;
      default: ;
    endcase
    case (o_mem_rd_mask)
      3'd0: i_mem_rd_data <= w;
      3'd1: i_mem_rd_data <= {16'd0, h};
      3'd2: i_mem_rd_data <= {24'd0, b};
      3'd3: i_mem_rd_data <= {{16{h[15]}}, h};
      3'd4: i_mem_rd_data <= {{24{b[7]}}, b};
      default: ;
    endcase
  end

  // Memory-port activity observed by the bench.
  int          wr_cycles = 0;
  int          rd_cycles = 0;
  logic [31:0] last_wr_addr = 32'd0;
  logic [1:0]  last_wr_mask = 2'd0;
  always @(negedge i_clk) begin
    if (o_mem_wr_mask != 2'd0) begin
      wr_cycles++;
      last_wr_addr = o_mem_address;
      last_wr_mask = o_mem_wr_mask;
    end
    if (o_mem_rd_mask != 3'd5) rd_cycles++;
  end

  task automatic clear_activity();
    wr_cycles = 0;
    rd_cycles = 0;
    last_wr_addr = 32'd0;
    last_wr_mask = 2'd0;
  endtask

  // Response monitor: compares every valid cycle against the head, pops on handshake.
  logic prev_valid = 1'b0;
  always @(negedge i_clk) begin
    if (i_reset && o_resp_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: rdata %h fault %b with empty scoreboard", o_resp_rdata, o_resp_fault);
      end else begin
        if (!prev_valid) check("resp_latency", 32'(cyc - q[0].acc), 32'(q[0].lat));
        check("resp_rdata", o_resp_rdata, q[0].rdata);
        check("resp_fault", {31'd0, o_resp_fault}, {31'd0, q[0].fault});
        if (i_resp_ready) void'(q.pop_front());
      end
    end
    prev_valid = i_reset && o_resp_valid;
  end

  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_fault);
    exp_t e;
    int n = 0;
    @(negedge i_clk);
    while (!o_req_ready && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    if (!o_req_ready) begin
      checks++;
      errors++;
      $display("FAIL req_ready_timeout: ready %b after %0d cycles, expected 1", o_req_ready, n);
      return;
    end
    i_req_valid  = 1'b1;
    i_req_we     = we;
    i_req_size   = size;
    i_req_signed = sgn;
    i_req_addr   = addr;
    i_req_wdata  = wdata;
    e.rdata = exp_rdata;
    e.fault = exp_fault;
    e.lat   = exp_fault ? 0 : 2;
    e.acc   = cyc + 1;
    q.push_back(e);
    @(negedge i_clk);
    i_req_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int n = 0; n < 40 && q.size() != 0; n++) @(negedge i_clk);
    @(negedge i_clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: %0d responses outstanding, expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"},  {31'd0, o_req_ready},  32'd1);
    check({tag, "_resp_valid"}, {31'd0, o_resp_valid}, 32'd0);
    check({tag, "_resp_rdata"}, o_resp_rdata,          32'd0);
    check({tag, "_resp_fault"}, {31'd0, o_resp_fault}, 32'd0);
    check({tag, "_mem_addr"},   o_mem_address,         32'd0);
    check({tag, "_mem_wdata"},  o_mem_wr_data,         32'd0);
    check({tag, "_wr_mask"},    {30'd0, o_mem_wr_mask}, 32'd0);
    check({tag, "_rd_mask"},    {29'd0, o_mem_rd_mask}, 32'd5);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge i_clk);
    check_reset_outputs("reset");
    i_reset = 1'b1;

    // Word store then word load.
    clear_activity();
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0);
    wait_done();
    check("store_wr_cycles", 32'(wr_cycles), 32'd1);
    check("store_wr_mask", {30'd0, last_wr_mask}, 32'd3);
    check("store_wr_addr", last_wr_addr, 32'h10);
    check("store_rd_cycles", 32'(rd_cycles), 32'd0);
    clear_activity();
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    wait_done();
    check("load_wr_cycles", 32'(wr_cycles), 32'd0);
    check("load_rd_cycles", 32'(rd_cycles), 32'd1);

    // Sub-word loads.
    issue(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0);
    issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'h000000DE, 1'b0);
    issue(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0);
    issue(1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 32'h0000BEEF, 1'b0);
    issue(1'b0, 2'd0, 1'b1, 32'h10, 32'h0, 32'hFFFFFFEF, 1'b0);
    wait_done();

    // Misaligned and illegal-size requests fault without touching memory.
    clear_activity();
    issue(1'b0, 2'd1, 1'b1, 32'h11, 32'h0, 32'd0, 1'b1);
    issue(1'b0, 2'd2, 1'b0, 32'h12, 32'h0, 32'd0, 1'b1);
    issue(1'b1, 2'd3, 1'b0, 32'h10, 32'h5555AAAA, 32'd0, 1'b1);
    wait_done();
    check("fault_wr_cycles", 32'(wr_cycles), 32'd0);
    check("fault_rd_cycles", 32'(rd_cycles), 32'd0);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    wait_done();

    // Out-of-range store.
    clear_activity();
`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
    issue(1'b1, 2'd2, 1'b0, 32'h1000, 32'hCAFEF00D, 32'd0, 1'b1);
    wait_done();
    check("bounds_wr_cycles", 32'(wr_cycles), 32'd0);
    issue(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
`else
    issue(1'b1, 2'd2, 1'b0, 32'h1000, 32'hCAFEF00D, 32'd0, 1'b0);
    wait_done();
    check("bounds_wr_cycles", 32'(wr_cycles), 32'd1);
    check("bounds_wr_mask", {30'd0, last_wr_mask}, 32'd3);
    check("bounds_wr_addr", last_wr_addr, 32'h1000);
    issue(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 32'hCAFEF00D, 1'b0);
`endif
    wait_done();

    // Back-pressure: response held, new requests ignored.
    @(posedge i_clk);
    #1 i_resp_ready = 1'b0;
    clear_activity();
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    for (int n = 0; n < 20 && !o_resp_valid; n++) @(negedge i_clk);
    check("bp_valid_seen", {31'd0, o_resp_valid}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      i_req_valid = 1'b1;
      i_req_we    = 1'b1;
      i_req_size  = 2'd2;
      i_req_addr  = 32'h10;
      i_req_wdata = 32'h0;
      @(negedge i_clk);
      check("bp_req_ready", {31'd0, o_req_ready}, 32'd0);
      check("bp_resp_valid", {31'd0, o_resp_valid}, 32'd1);
    end
    i_req_valid = 1'b0;
    @(posedge i_clk);
    #1 i_resp_ready = 1'b1;
    wait_done();
    check("bp_wr_cycles", 32'(wr_cycles), 32'd0);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    wait_done();

    // Reset during ACCESS of a store leaves memory untouched.
    issue(1'b1, 2'd2, 1'b0, 32'h20, 32'h12345678, 32'd0, 1'b0);
    wait_done();
    @(negedge i_clk);
    i_req_valid = 1'b1;
    i_req_we    = 1'b1;
    i_req_size  = 2'd2;
    i_req_addr  = 32'h20;
    i_req_wdata = 32'hAAAAAAAA;
    @(negedge i_clk);
    i_req_valid = 1'b0;
    check("access_wr_mask", {30'd0, o_mem_wr_mask}, 32'd3);
    #2 i_reset = 1'b0;
    #1 check_reset_outputs("midreset");
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b1;
    issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'h12345678, 1'b0);
    wait_done();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store sequencer sitting directly upstream of the word-banked data memory. Accepts one load or store request at a time from the execute stage over a valid/ready handshake, checks alignment and bounds, and drives the memory's address, write-mask and read-mask inputs for exactly one cycle. It captures the memory's registered read data and returns a response, with a fault flag, over a second valid/ready handshake.

## Interface
Parameters:
- `MEM_BYTES`, 4096: size of the addressable data memory in bytes; must be a power of two.

Ports:
- `i_clk`  in  1  clock; all state changes on the rising edge.
- `i_reset`  in  1  asynchronous, active-low reset.
- `i_req_valid`  in  1  request present.
- `o_req_ready`  out  1  unit can accept a request.
- `i_req_we`  in  1  1 = store, 0 = load.
- `i_req_size`  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = illegal.
- `i_req_signed`  in  1  sign-extend a load; ignored for word loads and stores.
- `i_req_addr`  in  32  byte address.
- `i_req_wdata`  in  32  store data, right-aligned.
- `o_resp_valid`  out  1  response present.
- `i_resp_ready`  in  1  consumer takes the response.
- `o_resp_rdata`  out  32  load result; 0 for stores and faults.
- `o_resp_fault`  out  1  request was rejected and had no memory side effect.
- `o_mem_address`  out  32  memory byte address.
- `o_mem_wr_data`  out  32  memory write data.
- `o_mem_wr_mask`  out  2  write mask: 0 = none, 1 = byte, 2 = half, 3 = word.
- `o_mem_rd_mask`  out  3  read mask: 0 = W, 1 = HZ, 2 = BZ, 3 = HE, 4 = BE, 5 = none.
- `i_mem_rd_data`  in  32  memory read data, valid one cycle after the access edge.

## Operation
The unit has four states. Its state register is reset to IDLE.

- **IDLE**
  - `o_req_ready` = 1.
  - On `i_req_valid`, the request is latched into registers.
  - Fault check (fault = 1 if any of these holds):
    - size is 3;
    - size is 1 and `addr[0]` ≠ 0;
    - size is 2 and `addr[1:0]` ≠ 0;
    - bounds check enabled (see Configuration) and `addr` ≥ `MEM_BYTES`.
  - On a fault, go to RESP with `o_resp_fault` = 1. No memory access occurs.
  - Otherwise go to ACCESS.
- **ACCESS** (exactly one cycle)
  - Memory ports are driven from the latched request.
  - A store uses wr_mask = size + 1 and rd_mask = 5.
  - A load uses wr_mask = 0 and a rd_mask chosen from size and signed:
    - word → 0;
    - half unsigned → 1, half signed → 3;
    - byte unsigned → 2, byte signed → 4.
  - Next state is CAPTURE.
- **CAPTURE** (one cycle)
  - Memory ports are idle.
  - For a load, `o_resp_rdata` is loaded from `i_mem_rd_data`; for a store it is loaded with 0.
  - Next state is RESP.
- **RESP**
  - `o_resp_valid` = 1. Response outputs are held stable until `i_resp_ready` = 1.
  - On that edge: go to IDLE and clear `o_resp_fault` and `o_resp_rdata` to 0.

Memory idle drive, in every state except ACCESS:
- `o_mem_wr_mask` = 0 and `o_mem_rd_mask` = 5;
- `o_mem_address` and `o_mem_wr_data` hold the last latched values.

Other rules:
- `o_mem_wr_data` passes `i_req_wdata` through unchanged; the memory uses the low bits according to the mask.
- `o_req_ready` is 0 in ACCESS, CAPTURE and RESP. No request is accepted while a response is pending.

## Timing
- Reset values: state = IDLE, `o_req_ready` = 1, `o_resp_valid` = 0, `o_resp_rdata` = 0, `o_resp_fault` = 0, `o_mem_address` = 0, `o_mem_wr_data` = 0, `o_mem_wr_mask` = 0, `o_mem_rd_mask` = 5.
- Memory port outputs are derived from the state register. Asserting reset during ACCESS forces wr_mask to 0 immediately, so no write takes effect.
- Latency:
  - Accept edge T. ACCESS during T+1, CAPTURE during T+2, `o_resp_valid` from T+3.
  - Faulting request: `o_resp_valid` from T+1.
- Throughput: with `i_resp_ready` tied high, one access every 4 cycles (2 cycles for a fault).
- Back-pressure: RESP is held indefinitely while `i_resp_ready` = 0.
- A request presented during a RESP→IDLE edge is not accepted on that edge; it is accepted on the next edge.

## Configuration
- `MEM_ACCESS_BOUNDS_CHECK_EN` defined: an address ≥ `MEM_BYTES` faults in IDLE and is never issued to memory.
- Not defined: no bounds check. Upper address bits pass through, and the memory aliases them.

## Test plan
- **Word store then load.** Store 0xDEADBEEF at addr 0x10, size 2. Then load from addr 0x10, size 2. Required: wr_mask = 3 for exactly one cycle; the load returns 0xDEADBEEF with `o_resp_valid` at T+3.
- **Signed and unsigned byte loads.** After the word store above, load addr 0x13 with size 0, signed → 0xFFFFFFDE. Load addr 0x13 with size 0, unsigned → 0x000000DE. Load addr 0x12 with size 1, signed → 0xFFFFDEAD.
- **Misalignment.** Load at addr 0x11 with size 1 → fault = 1, rdata = 0, response at T+1, memory masks never leave 0/5. Repeat with addr 0x12, size 2 → fault.
- **Bounds.** Store at addr 0x1000 with macro defined → fault, no write. Without the macro → a write occurs with wr_mask = 3 and address 0x1000, and a later load from 0x0 returns the stored data.
- **Back-pressure.** Hold `i_resp_ready` = 0 for 5 cycles in RESP. Required: rdata, fault and valid stay stable, `o_req_ready` = 0, and a new `i_req_valid` is ignored.
- **Reset mid-access.** Drop `i_reset` during ACCESS of a store to 0x20. Required: all outputs return to reset values immediately, and the word at 0x20 is unchanged.
